vic_cfg_bridge: RTL

//  CPU-side initiator for the VIC configuration register port. Converts one
//  32-bit memory-mapped access into a sequence of 4-bit register transfers.

---
 rtl/vic_cfg_bridge.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/vic_cfg_bridge.sv
// rtl/vic_cfg_bridge.sv - CPU word access to VIC nibble register port bridge.
// One 32-bit access becomes eight fixed-latency 4-bit register transfers.
module vic_cfg_bridge #(
  parameter int NIB_PER_WORD = 8,
  parameter int REG_AW       = 5,
  parameter int NIB_W        = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_req,
  input  logic                            i_we,
  input  logic [REG_AW-$clog2(NIB_PER_WORD)-1:0] i_word,
  input  logic [NIB_PER_WORD*NIB_W-1:0]   i_wdata,
  input  logic [NIB_PER_WORD-1:0]         i_nmask,
  output logic                            o_busy,
  output logic                            o_ack,
  output logic [NIB_PER_WORD*NIB_W-1:0]   o_rdata,
  output logic [REG_AW-1:0]               o_VIC_regaddr,
  output logic [NIB_W-1:0]                o_VIC_data,
  output logic                            o_VIC_we,
  input  logic [NIB_W-1:0]                i_VIC_data
);

  localparam int IDX_W  = $clog2(NIB_PER_WORD);
  localparam int WORD_W = REG_AW - IDX_W;
  localparam int DATA_W = NIB_PER_WORD * NIB_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_nxt;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NIB_PER_WORD-1:0] nmask_q, nmask_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [REG_AW-1:0]   regaddr_q, regaddr_d;
  logic [NIB_W-1:0]    vdata_q, vdata_d;
  logic                vwe_q, vwe_d;

  // Index wraps within 3 bits, so it never carries into the word field.
  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    nmask_d   = nmask_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    regaddr_d = regaddr_q;
    vdata_d   = vdata_q;
    vwe_d     = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (i_req) begin
          word_d    = i_word;
          wdata_d   = i_wdata;
          nmask_d   = i_nmask;
          idx_d     = '0;
          busy_d    = 1'b1;
          regaddr_d = {i_word, {IDX_W{1'b0}}};
          if (i_we) begin
            state_d = WR;
            vdata_d = i_wdata[NIB_W-1:0];
            vwe_d   = i_nmask[0];
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end else begin
          idx_d     = idx_nxt;
          regaddr_d = {word_q, idx_nxt};
          vdata_d   = wdata_q[NIB_W*int'(idx_nxt) +: NIB_W];
          vwe_d     = nmask_q[idx_nxt];
        end
      end
      RD: begin
        rdata_d[NIB_W*int'(idx_q) +: NIB_W] = i_VIC_data;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end else begin
          idx_d     = idx_nxt;
          regaddr_d = {word_q, idx_nxt};
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      word_q    <= '0;
      wdata_q   <= '0;
      nmask_q   <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      regaddr_q <= '0;
      vdata_q   <= '0;
      vwe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      nmask_q   <= nmask_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      regaddr_q <= regaddr_d;
      vdata_q   <= vdata_d;
      vwe_q     <= vwe_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_ack         = ack_q;
  assign o_rdata       = rdata_q;
  assign o_VIC_regaddr = regaddr_q;
  assign o_VIC_data    = vdata_q;
  assign o_VIC_we      = vwe_q;

endmodule
